asfifo_rd_drain: RTL and testbench

Read-side consumer for the asynchronous FIFO. Sits in the rclk domain and drains the FIFO pop interface (rempty / rinc / rdata, one-cycle read latency) into a valid/ready stream for downstream logic. Holds a 2-entry skid buffer so throughput reaches one word per clock with no loss under backpressure. Also counts delivered words.

---
 rtl/asfifo_rd_drain_pkg.sv | 30 +++
 rtl/asfifo_rd_drain_chk.sv | 27 ++
 rtl/asfifo_rd_drain_skid_buf2.sv | 45 ++++
 rtl/asfifo_rd_drain.sv | 83 ++++++++
 tb/tb_asfifo_rd_drain.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/asfifo_rd_drain_pkg.sv
// Shared constants for the async-FIFO read-side drain: default word width
// (kept equal to the FIFO WIDTH) and the skid-buffer geometry.
package asfifo_rd_drain_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int SKID_DEPTH    = 2;
    localparam int OCC_W         = 2;

    localparam logic [OCC_W-1:0] OCC_EMPTY = 2'd0;
    localparam logic [OCC_W-1:0] OCC_FULL  = 2'd2;

    // Next buffer occupancy given a write and/or a read this cycle; a
    // simultaneous write and read leaves the occupancy unchanged.
    function automatic logic [OCC_W-1:0] occ_next(
        input logic [OCC_W-1:0] occ,
        input logic             wr,
        input logic             rd
    );
        logic [OCC_W-1:0] v;
        if (wr && !rd) begin
            v = occ + 2'd1;
        end else if (rd && !wr) begin
            v = occ - 2'd1;
        end else begin
            v = occ;
        end
        return v;
    endfunction

endpackage

// File: rtl/asfifo_rd_drain_chk.sv
// Invariant checker for the drain's skid buffer; contributes no logic.
module asfifo_rd_drain_chk
    import asfifo_rd_drain_pkg::*;
(
    input logic             clk,
    input logic             rstn,
    input logic             wr_en,
    input logic             rd_en,
    input logic [OCC_W-1:0] occ
);

    // The credit logic must never launch a word that lands in a full buffer.
    a_no_capture_when_full: assert property (
        @(posedge clk) disable iff (!rstn) !(wr_en && (occ == OCC_FULL))
    );

    // A pop can only happen while a word is held.
    a_no_pop_when_empty: assert property (
        @(posedge clk) disable iff (!rstn) !(rd_en && (occ == OCC_EMPTY))
    );

    // Occupancy stays within the two entries.
    a_occ_range: assert property (
        @(posedge clk) disable iff (!rstn) (occ <= OCC_FULL)
    );

endmodule

// File: rtl/asfifo_rd_drain_skid_buf2.sv
// Two-entry in-order queue that absorbs FIFO read data. Entries are
// registers, so the read port carries no combinational path from wr_data.
module asfifo_rd_drain_skid_buf2
    import asfifo_rd_drain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] r_mem [SKID_DEPTH];
    logic             r_head;
    logic             r_tail;
    logic [OCC_W-1:0] r_occ;

    // Queue state: write at tail, advance head on read, track occupancy.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mem[0] <= {WIDTH{1'b0}};
            r_mem[1] <= {WIDTH{1'b0}};
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_occ    <= OCC_EMPTY;
        end else begin
            if (wr_en) begin
                r_mem[r_tail] <= wr_data;
                r_tail        <= ~r_tail;
            end
            if (rd_en) begin
                r_head <= ~r_head;
            end
            r_occ <= occ_next(r_occ, wr_en, rd_en);
        end
    end

    assign rd_data = r_mem[r_head];
    assign occ     = r_occ;

endmodule

// File: rtl/asfifo_rd_drain.sv
// Read-domain consumer of the async FIFO: pops words with credit-based flow
// control, absorbs the one-cycle read latency in a 2-entry skid buffer and
// presents a valid/ready stream, counting delivered words.
module asfifo_rd_drain
    import asfifo_rd_drain_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             rempty,
    output logic             rinc,
    input  logic [WIDTH-1:0] rdata,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready,
    output logic [CNT_W-1:0] rd_count
);

    logic             w_pop;
    logic             w_rinc;
    logic [2:0]       w_commit;
    logic [OCC_W-1:0] w_occ;
    logic             r_inflight;
    logic [CNT_W-1:0] r_rd_count;

    // Pop credit: words held plus the one in flight, less the one leaving now,
    // must leave a free slot. Held low during reset so no pop escapes.
    always_comb begin
        w_pop    = m_valid & m_ready;
        w_commit = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
        if (rstn && en && !rempty && (w_commit < 3'd2)) begin
            w_rinc = 1'b1;
        end else begin
            w_rinc = 1'b0;
        end
    end

    // A popped word arrives one cycle later and is always captured then.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rinc;
        end
    end

    // Delivered-word counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_count <= {CNT_W{1'b0}};
        end else if (w_pop) begin
            r_rd_count <= r_rd_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    asfifo_rd_drain_skid_buf2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (r_inflight),
        .wr_data (rdata),
        .rd_en   (w_pop),
        .rd_data (m_data),
        .occ     (w_occ)
    );

    asfifo_rd_drain_chk u_chk (
        .clk   (clk),
        .rstn  (rstn),
        .wr_en (r_inflight),
        .rd_en (w_pop),
        .occ   (w_occ)
    );

    assign rinc     = w_rinc;
    assign m_valid  = (w_occ != OCC_EMPTY);
    assign rd_count = r_rd_count;

endmodule

// File: tb/tb_asfifo_rd_drain.sv
// Bench for asfifo_rd_drain: a queue-based FIFO stand-in feeds the DUT and a
// queue-level model of the expected output stream checks every cycle.
module tb_asfifo_rd_drain;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rstn;
    logic             en;
    logic             rempty;
    logic             rinc;
    logic [WIDTH-1:0] rdata;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    logic             m_ready;
    logic [CNT_W-1:0] rd_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] fifo_q[$];  // words written into the FIFO, not yet popped
    logic [WIDTH-1:0] mbuf[$];    // words due at the output, oldest first
    logic             pend_v;     // a word was popped last cycle
    logic [WIDTH-1:0] pend_d;
    int               delivered;
    int               cyc;
    int               first_rinc;
    int               first_valid;

    always #5 clk = ~clk;

    asfifo_rd_drain #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .rempty   (rempty),
        .rinc     (rinc),
        .rdata    (rdata),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_ready  (m_ready),
        .rd_count (rd_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, required 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: check outputs mid-cycle, then advance FIFO and model after the edge.
    task automatic tick();
        logic exp_pop;
        logic exp_rinc;
        logic obs_rinc;
        int   credit;
        rempty = (fifo_q.size() == 0);
        @(negedge clk);
        cyc++;
        exp_pop  = (mbuf.size() != 0) && m_ready;
        credit   = mbuf.size() + (pend_v ? 1 : 0) - (exp_pop ? 1 : 0);
        exp_rinc = en && !rempty && (credit < 2);
        obs_rinc = rinc;
        chk("rinc", 32'(rinc), 32'(exp_rinc));
        chk("m_valid", 32'(m_valid), 32'(mbuf.size() != 0));
        if (mbuf.size() != 0) chk("m_data", 32'(m_data), 32'(mbuf[0]));
        chk("rd_count", 32'(rd_count), 32'(delivered % (1 << CNT_W)));
        if (obs_rinc && first_rinc < 0) first_rinc = cyc;
        if (m_valid && first_valid < 0) first_valid = cyc;
        @(posedge clk);
        #1;
        if (exp_pop) begin
            void'(mbuf.pop_front());
            delivered++;
        end
        if (pend_v) mbuf.push_back(pend_d);
        if (obs_rinc && fifo_q.size() != 0) begin
            pend_d = fifo_q.pop_front();
            pend_v = 1'b1;
            rdata  = pend_d;
        end else begin
            pend_v = 1'b0;
            rdata  = WIDTH'($urandom);
        end
    endtask

    task automatic drain(input string tag);
        int n;
        n       = 0;
        en      = 1'b1;
        m_ready = 1'b1;
        while ((fifo_q.size() != 0 || mbuf.size() != 0 || pend_v) && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(n < 200), 32'd1);
    endtask

    initial begin
        int               base;
        logic [WIDTH-1:0] w0;
        rstn = 1'b0; en = 1'b0; m_ready = 1'b0; rempty = 1'b1;
        rdata = '0; pend_v = 1'b0; pend_d = '0; delivered = 0; cyc = 0;
        first_rinc = -1; first_valid = -1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rinc", 32'(rinc), 32'd0);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_data", 32'(m_data), 32'd0);
        chk("rst_count", 32'(rd_count), 32'd0);
        rstn = 1'b1;

        // Basic three words with latency check
        fifo_q.push_back(8'h24); fifo_q.push_back(8'h81); fifo_q.push_back(8'h09);
        en = 1'b1; m_ready = 1'b1;
        repeat (8) tick();
        chk("basic_latency", 32'(first_valid - first_rinc), 32'd2);
        chk("basic_count", 32'(rd_count), 32'd3);

        // Streaming 20 words, counter passes its wrap point (3+20 = 23 -> 7)
        for (int i = 0; i < 20; i++) fifo_q.push_back(WIDTH'($urandom));
        repeat (24) tick();
        chk("stream_count_wrap", 32'(rd_count), 32'd7);

        // Backpressure
        drain("drain_pre_bp");
        base = delivered;
        for (int i = 0; i < 10; i++) fifo_q.push_back(WIDTH'($urandom));
        w0 = fifo_q[0];
        m_ready = 1'b0;
        repeat (8) tick();
        chk("bp_hold_word0", 32'(m_data), 32'(w0));
        chk("bp_two_popped", 32'(fifo_q.size()), 32'd8);
        drain("bp_drain");
        chk("bp_count", 32'(rd_count), 32'((base + 10) % (1 << CNT_W)));

        // Enable gate, then drop en with a word in flight
        base = delivered;
        en = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(WIDTH'($urandom));
        repeat (5) tick();
        chk("en_gate_fifo", 32'(fifo_q.size()), 32'd4);
        chk("en_gate_valid", 32'(m_valid), 32'd0);
        en = 1'b1;
        tick();
        en = 1'b0;
        repeat (6) tick();
        chk("en_drop_inflight", 32'(rd_count), 32'((base + 1) % (1 << CNT_W)));
        chk("en_drop_fifo", 32'(fifo_q.size()), 32'd3);
        drain("en_drain");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            if (($urandom % 2) == 0 && fifo_q.size() < 16) fifo_q.push_back(WIDTH'($urandom));
            en      = (($urandom % 4) != 0);
            m_ready = (($urandom % 3) != 0);
            tick();
        end
        drain("rnd_drain");

        // Reset mid-stream with a full buffer
        for (int i = 0; i < 6; i++) fifo_q.push_back(WIDTH'($urandom));
        en = 1'b1; m_ready = 1'b0;
        repeat (4) tick();
        #2 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_rinc", 32'(rinc), 32'd0);
        chk("mid_rst_count", 32'(rd_count), 32'd0);
        fifo_q.delete(); mbuf.delete(); pend_v = 1'b0; delivered = 0; rempty = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        fifo_q.push_back(8'hA5); fifo_q.push_back(8'h5A); fifo_q.push_back(8'h3C);
        drain("post_rst_drain");
        chk("post_rst_count", 32'(rd_count), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
